// File: rtl/mac_acc_pipe.sv
// Pipelined signed multiply-accumulate with read-modify-write of an external
// partial-sum register file, write-back forwarding, saturation and range checks.
module mac_acc_pipe #(
    parameter int DW       = 16,
    parameter int AW       = 7,
    parameter int MULT_LAT = 5,
    parameter int DEPTH    = 100,
    parameter int FRAC     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [AW-1:0]        in_addr,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [DW-1:0] in_weight,
    output logic [AW-1:0]        rf_rd_addr,
    input  logic signed [DW-1:0] rf_rd_data,
    output logic                 rf_wr_en,
    output logic [AW-1:0]        rf_wr_addr,
    output logic signed [DW-1:0] rf_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag,
    output logic                 addr_err,
    input  logic                 clear_flags
);

    localparam int LA = MULT_LAT - 1;
    localparam logic signed [2*DW:0] SMAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW:0] SMIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

    logic [MULT_LAT-1:0]    vld_q;
    logic [MULT_LAT-1:0]    first_q;
    logic [MULT_LAT-1:0]    last_q;
    logic [AW-1:0]          addr_q [MULT_LAT];
    logic signed [2*DW-1:0] prod_q [MULT_LAT];
    logic signed [2*DW-1:0] prod_in;

    logic                 wb_vld_q, wb_vld_d;
    logic                 wb_last_q, wb_last_d;
    logic [AW-1:0]        wb_addr_q, wb_addr_d;
    logic signed [DW-1:0] wb_data_q, wb_data_d;
    logic                 sat_q, sat_d;
    logic                 err_q, err_d;

    logic                   in_range;
    logic signed [2*DW-1:0] p_a;
    logic signed [DW-1:0]   operand;
    logic signed [2*DW:0]   sum;
    logic                   clip_hi;
    logic                   clip_lo;

    assign prod_in = (2*DW)'(in_data) * (2*DW)'(in_weight);

    // Control tags ride alongside the product; first/last are masked by valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                addr_q[i] <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            vld_q[0]   <= in_valid;
            first_q[0] <= in_valid & in_first;
            last_q[0]  <= in_valid & in_last;
            addr_q[0]  <= in_addr;
            prod_q[0]  <= prod_in;
            for (int i = 1; i < MULT_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                addr_q[i]  <= addr_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    assign rf_rd_addr = addr_q[LA];
    assign in_range   = 32'(addr_q[LA]) < 32'(DEPTH);
    assign p_a        = prod_q[LA] >>> FRAC;

    always_comb begin
        operand = rf_rd_data;
        if (first_q[LA]) begin
            operand = '0;
        end else if (wb_vld_q && wb_addr_q == addr_q[LA]) begin
            operand = wb_data_q;
        end
    end

    assign sum     = {{(DW+1){operand[DW-1]}}, operand} + {p_a[2*DW-1], p_a};
    assign clip_hi = sum > SMAX;
    assign clip_lo = sum < SMIN;

    always_comb begin
        wb_vld_d  = vld_q[LA] & in_range;
        wb_last_d = vld_q[LA] & last_q[LA];
        wb_addr_d = addr_q[LA];
        wb_data_d = sum[DW-1:0];
        if (clip_hi) begin
            wb_data_d = {1'b0, {(DW-1){1'b1}}};
        end else if (clip_lo) begin
            wb_data_d = {1'b1, {(DW-1){1'b0}}};
        end
        sat_d = sat_q | (wb_vld_d & (clip_hi | clip_lo));
        err_d = err_q | (vld_q[LA] & ~in_range);
        if (clear_flags) begin
            sat_d = 1'b0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_vld_q  <= 1'b0;
            wb_last_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wb_vld_q  <= wb_vld_d;
            wb_last_q <= wb_last_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
        end
    end

    assign rf_wr_en   = wb_vld_q;
    assign rf_wr_addr = wb_addr_q;
    assign rf_wr_data = wb_data_q;
    assign done       = wb_last_q;
    assign busy       = (|vld_q) | wb_vld_q;
    assign sat_flag   = sat_q;
    assign addr_err   = err_q;

endmodule
